apb3_to_ahbl_bridge: RTL and testbench

- APB3 completer that turns each APB3 transfer into one single-beat 32-bit AHB-Lite transfer, acting as the AHB-Lite master.
- This is the reverse path of the team's AHB-to-APB3 bridge. It lets an APB-side agent (debug/config master) reach AHB memory and peripherals.
- Single clock domain; one transfer outstanding at a time.

---
 rtl/apb_ahb_bridge_pkg.sv | 22 ++
 rtl/apb3_to_ahbl_bridge.sv | 183 ++++++++++++++++++
 tb/tb_apb3_to_ahbl_bridge.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_ahb_bridge_pkg.sv
// Shared types and AHB-Lite encodings for the APB3-to-AHB-Lite bridge.
package apb_ahb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb3_to_ahbl_bridge.sv
// APB3 completer that replays each APB transfer as one single-beat AHB-Lite word transfer.
// Optional posted writes are enabled by defining APB2AHB_WPOST_EN.
module apb3_to_ahbl_bridge
  import apb_ahb_bridge_pkg::*;
#(
  parameter int          APB_AWIDTH = 32,
  parameter logic [31:0] AHB_BASE   = 32'h0000_0000,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [APB_AWIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP,
  output logic                  POSTED_ERR,
  output logic [1:0]            dbg_state
);

  // Handshake: an APB transfer is accepted from IDLE whenever PSEL is high
  // (setup or missed setup); PREADY pulses for exactly one cycle to end it.
  // On AHB, NONSEQ is held until HREADY=1 accepts the address; the data
  // phase ends on the next HREADY=1.

  state_t      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic        err_q, err_d;
  logic [31:0] paddr_ext;
  logic        unused_ok;

`ifdef APB2AHB_WPOST_EN
  logic        posted_q, posted_d;
  logic        posted_err_q, posted_err_d;
`endif

  assign paddr_ext = 32'(PADDR);
  assign unused_ok = HRESP[1];

  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    err_d     = err_q;
`ifdef APB2AHB_WPOST_EN
    posted_d     = posted_q;
    posted_err_d = posted_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (PSEL) begin
          haddr_d  = word_align(AHB_BASE + paddr_ext);
          hwrite_d = PWRITE;
          hwdata_d = PWDATA;
          htrans_d = HTRANS_NONSEQ;
          state_d  = ST_ADDR;
`ifdef APB2AHB_WPOST_EN
          // A posted write is acknowledged now; the AHB side finishes on its own.
          posted_d = PWRITE;
          pready_d = PWRITE;
          if (PWRITE) prdata_d = 32'h0;
`endif
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          err_d    = 1'b0;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!HREADY) begin
          // First cycle of the two-cycle ERROR response.
          if (HRESP[0]) err_d = 1'b1;
        end else begin
`ifdef APB2AHB_WPOST_EN
          if (posted_q) begin
            posted_err_d = posted_err_q | err_q | HRESP[0];
            posted_d     = 1'b0;
            state_d      = ST_IDLE;
          end else begin
`else
          begin
`endif
            prdata_d  = (hwrite_q || HRESP[0]) ? 32'h0 : HRDATA;
            pslverr_d = err_q | HRESP[0];
            pready_d  = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q   <= ST_IDLE;
      haddr_q   <= 32'h0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= 32'h0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      err_q     <= err_d;
    end
  end

`ifdef APB2AHB_WPOST_EN
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      posted_q     <= 1'b0;
      posted_err_q <= 1'b0;
    end else begin
      posted_q     <= posted_d;
      posted_err_q <= posted_err_d;
    end
  end

  assign POSTED_ERR = posted_err_q;
`else
  assign POSTED_ERR = 1'b0;
`endif

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb3_to_ahbl_bridge.sv
// Scoreboard bench for apb3_to_ahbl_bridge: APB driver, AHB-Lite slave model, PREADY monitor.
`timescale 1ns/1ps
module tb_apb3_to_ahbl_bridge;

  localparam logic [31:0] BASE = 32'h4000_0001;
`ifdef APB2AHB_WPOST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        psel, penable, pwrite, pready, pslverr, hwrite, hready, posted_err;
  logic [31:0] paddr, pwdata, prdata, haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp, dbg_state;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  apb3_to_ahbl_bridge #(
    .APB_AWIDTH(32), .AHB_BASE(BASE), .HPROT_VAL(4'b0011)
  ) dut (
    .HCLK(clk), .HRESETN(rst_n),
    .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp),
    .POSTED_ERR(posted_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [32:0] exp_apb_q[$];   // {pslverr, prdata}
  logic [64:0] exp_ahb_q[$];   // {hwrite, haddr, hwdata}
  logic [8:0]  cfg_q[$];       // {error, addr waits, data waits}
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  bit exp_posted_err = 1'b0;
  bit prev_write = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h3C3C_A5A5;
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] p);
    logic [31:0] s;
    s = BASE + p;
    s[1:0] = 2'b00;
    return s;
  endfunction

  // ---------------- AHB-Lite slave model ----------------
  initial begin
    int ph, cnt;
    logic [31:0] cap_a, exp_wd;
    logic cap_w, first;
    logic [8:0] cfg;
    logic [64:0] e;
    ph = 0; cnt = 0; cap_a = 0; cap_w = 0; first = 0; cfg = 0; exp_wd = 0;
    hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      hready = 1'b1;
      hresp = 2'b00;
      if (!rst_n) begin
        ph = 0;
        continue;
      end
      if (ph == 0 && htrans == 2'b10) begin
        if (cfg_q.size() == 0) begin
          chk("unexpected_nonseq", 1, 0);
          cfg = 9'h0;
        end else cfg = cfg_q.pop_front();
        cap_a = haddr; cap_w = hwrite; cnt = int'(cfg[7:4]); first = 1'b1; ph = 1;
      end
      if (ph == 1) begin
        if (!first) begin
          chk("haddr_stable", haddr, cap_a);
          chk("htrans_stable", htrans, 2'b10);
          chk("hwrite_stable", hwrite, cap_w);
        end
        first = 1'b0;
        if (cnt > 0) begin
          hready = 1'b0;
          cnt--;
        end else begin
          if (exp_ahb_q.size() == 0) begin
            chk("ahb_queue_empty", 1, 0);
            exp_wd = 32'h0;
          end else begin
            e = exp_ahb_q.pop_front();
            chk("haddr", haddr, e[63:32]);
            chk("hwrite", hwrite, e[64]);
            exp_wd = e[31:0];
          end
          cnt = int'(cfg[3:0]);
          if (cfg[8] && cnt == 0) cnt = 1;
          ph = 2;
        end
      end else if (ph == 2) begin
        chk("no_overlap_htrans", htrans, 2'b00);
        hrdata = slave_mem.exists(cap_a) ? slave_mem[cap_a] : dflt(cap_a);
        if (cnt > 0) begin
          hready = 1'b0;
          hresp = (cnt == 1 && cfg[8]) ? 2'b01 : 2'b00;
          cnt--;
        end else begin
          hresp = cfg[8] ? 2'b01 : 2'b00;
          if (cap_w) begin
            chk("hwdata", hwdata, exp_wd);
            if (!cfg[8]) slave_mem[cap_a] = hwdata;
          end
          ph = 0;
        end
      end
    end
  end

  // ---------------- APB response monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && pready) begin
        if (exp_apb_q.size() == 0) chk("unexpected_pready", 1, 0);
        else begin
          e = exp_apb_q.pop_front();
          chk("prdata", prdata, e[31:0]);
          chk("pslverr", pslverr, e[32]);
        end
      end
    end
  end

  // ---------------- APB driver ----------------
  task automatic apb_xfer(input logic [31:0] pa, input bit wr, input logic [31:0] wd,
                          input int aw, input int dw, input bit err, input bit miss);
    logic [31:0] a, rd;
    int dwe, exp_lat, cyc;
    a = model_addr(pa);
    dwe = (err && dw == 0) ? 1 : dw;
    cfg_q.push_back({err, 4'(aw), 4'(dw)});
    exp_ahb_q.push_back({wr, a, wd});
    rd = model_mem.exists(a) ? model_mem[a] : dflt(a);
    if (wr) begin
      exp_apb_q.push_back(POSTED ? 33'h0 : {err, 32'h0});
      if (!err) model_mem[a] = wd;
      if (POSTED && err) exp_posted_err = 1'b1;
    end else begin
      exp_apb_q.push_back({err, err ? 32'h0 : rd});
    end
    exp_lat = (POSTED && wr) ? 1 : 3 + aw + dwe;
    if (miss) exp_lat++;
    psel = 1'b1; penable = miss; paddr = pa; pwrite = wr; pwdata = wd;
    if (!miss) begin
      @(posedge clk); #1;
      penable = 1'b1;
    end
    cyc = 1;
    while (!pready && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!pready) chk("pready_timeout", 0, 1);
    else if (!(POSTED && prev_write)) chk("access_cycles", cyc, exp_lat);
    prev_write = wr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [31:0] pa;
    psel = 0; penable = 0; paddr = 0; pwrite = 0; pwdata = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", hwrite, 1'b0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", pready, 1'b0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_posted_err", posted_err, 1'b0);
    chk("hsize", hsize, 3'b010);
    chk("hburst", hburst, 3'b000);
    chk("hprot", hprot, 4'b0011);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed read with known data at BASE+0x10.
    model_mem[32'h4000_0010] = 32'hCAFE_F00D;
    slave_mem[32'h4000_0010] = 32'hCAFE_F00D;
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);

    // Reset while the address phase is stalled.
    cfg_q.push_back({1'b0, 4'd3, 4'd0});
    exp_ahb_q.push_back({1'b0, model_addr(32'h20), 32'h0});
    psel = 1'b1; penable = 1'b0; paddr = 32'h20; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #3;
    chk("htrans_before_reset", htrans, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("arst_htrans", htrans, 2'b00);
    chk("arst_haddr", haddr, 32'h0);
    chk("arst_pready", pready, 1'b0);
    chk("arst_prdata", prdata, 32'h0);
    chk("arst_posted_err", posted_err, 1'b0);
    psel = 1'b0; penable = 1'b0;
    exp_ahb_q.delete(); cfg_q.delete(); exp_apb_q.delete();
    exp_posted_err = 1'b0; prev_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stalled write, read-back, error read, recovery read.
    apb_xfer(32'h0000_0040, 1'b1, 32'hA5A5_1234, 2, 3, 1'b0, 1'b0);
    apb_xfer(32'h0000_0040, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 0, 1, 1'b1, 1'b0);
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);

    // Back-to-back write then read across the 2^32 wrap.
    apb_xfer(32'h0000_0004, 1'b1, 32'h1357_2468, 0, 0, 1'b0, 1'b0);
    apb_xfer(32'hBFFF_FFFF, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    apb_xfer(32'h0000_0004, 1'b0, 32'h0, 1, 0, 1'b0, 1'b1);
    apb_xfer(32'h0000_0030, 1'b1, 32'hDEAD_BEEF, 0, 2, 1'b1, 1'b0);
    apb_xfer(32'h0000_0030, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);

    // Randomized traffic over a small window plus the wrap region.
    for (int i = 0; i < 60; i++) begin
      pa = ($urandom_range(0, 1) == 0 ? 32'h0000_0100 : 32'hBFFF_FFF8) + 32'($urandom_range(0, 15));
      apb_xfer(pa, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    w = 0;
    while ((exp_apb_q.size() != 0 || exp_ahb_q.size() != 0) && w < 100) begin
      @(posedge clk);
      w++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("apb_queue_drained", exp_apb_q.size(), 0);
    chk("ahb_queue_drained", exp_ahb_q.size(), 0);
    chk("cfg_queue_drained", cfg_q.size(), 0);
    chk("posted_err_final", posted_err, exp_posted_err);
    chk("htrans_idle_final", htrans, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
